// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, buffers words from the combinational
// instruction memory in a small queue, and parks on the branch-to-self terminator.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | fetching one word per cycle whenever the queue has room
// ST_HALT | halt word enqueued; fetch stopped, queue keeps draining
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          QDEPTH    = 2,
    parameter logic [31:0] HALT_WORD = 32'hEAFF_FFFE
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc8,
    input  logic        instr_ready,
    output logic        halted
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(QDEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [31:0]   RESET_FPC = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [31:0]   fpc;
    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   q_pc    [QDEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          pop, push, push_halt;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;
    assign push        = (state == ST_RUN) & ~branch_valid & ((count < FULL_CNT) | pop);
    assign push_halt   = push & (imem_rd == HALT_WORD);

    // fpc is kept word-aligned, so it drives the memory address directly
    assign imem_a = fpc;
    assign halted = (state == ST_HALT);

    // Gating by the registered count makes an empty queue read as zero
    assign instr     = instr_valid ? q_instr[rd_ptr] : '0;
    assign instr_pc  = instr_valid ? q_pc[rd_ptr] : '0;
    assign instr_pc8 = instr_valid ? (q_pc[rd_ptr] + 32'd8) : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (branch_valid)   state_nxt = ST_RUN;
        else if (push_halt) state_nxt = ST_HALT;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fpc    <= RESET_FPC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (branch_valid) begin
            fpc    <= branch_target & 32'hFFFF_FFFC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (!push_halt) fpc <= fpc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            q_instr[wr_ptr] <= imem_rd;
            q_pc[wr_ptr]    <= fpc;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage for the single-issue ARM core. Owns the fetch PC and drives the word-aligned address to the combinational instruction memory, which returns the word in the same cycle. Buffers fetched words in a small FIFO and hands them to decode over a valid/ready handshake. Handles branch redirects from execute and parks on the branch-to-self terminator (0xEAFFFFFE).

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded at reset; bits [1:0] are ignored.
QDEPTH, 2, instruction queue entries; must be a power of two and >= 2.
HALT_WORD, 32'hEAFFFFFE, encoding that stops fetch ("b .").

Ports:
clk  in  1  rising-edge clock.
reset_n  in  1  synchronous reset, active-low.
imem_a  out  32  instruction memory byte address, always {fpc[31:2],2'b00}.
imem_rd  in  32  instruction word for imem_a, valid in the same cycle (combinational).
branch_valid  in  1  redirect request from execute.
branch_target  in  32  redirect byte address; bits [1:0] are forced to 0.
instr_valid  out  1  queue head is valid.
instr  out  32  queue head instruction word.
instr_pc  out  32  byte address of the head instruction.
instr_pc8  out  32  instr_pc + 8 (ARM R15 read value), mod 2^32.
instr_ready  in  1  decode accepts the head this cycle.
halted  out  1  fetch is stopped on HALT_WORD.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- Reset (reset_n=0 at an edge):
  - fpc <= RESET_PC & ~3.
  - Queue is emptied: count=0, rd_ptr=wr_ptr=0.
  - State goes to RUN.
  - Resulting outputs: instr_valid=0, halted=0, instr, instr_pc and instr_pc8 read 0.
  - Reset takes priority over every other input, including mid-redirect and in HALT.
- States:
  - RUN: fetching.
  - HALT: fetch stopped; the queue keeps draining.
- pop = instr_valid & instr_ready.
- push = (state==RUN) & ~branch_valid & (count<QDEPTH | pop).
  - A push writes {fpc, imem_rd} at wr_ptr.
  - On a push, fpc <= fpc+4 (wraps from 0xFFFFFFFC to 0).
  - On a push where imem_rd==HALT_WORD: the word is still enqueued, state <= HALT, fpc is not incremented.
- Full queue without a pop: no push, fpc holds.
- Simultaneous push and pop while full: allowed; count is unchanged.
- Pointers wrap modulo QDEPTH.
- count update: count += push - pop. Never exceeds QDEPTH and never underflows.
- Latency:
  - First valid instruction appears at the first edge after reset deasserts. That is one cycle of instr_valid=0 after reset.
  - With instr_ready held high, the queue sustains 1 instruction per cycle.
- Redirect (branch_valid=1 at an edge, reset_n=1):
  - Queue flushes (count=0, pointers reset to 0).
  - fpc <= branch_target & ~3.
  - state <= RUN, which also clears HALT.
  - No push occurs in that cycle.
  - A pop in that cycle is still a completed transfer for decode; the flush discards all remaining entries.
  - Next cycle: instr_valid=0 (one bubble). The cycle after that: the target instruction is valid.
- halted = (state==HALT). It asserts the cycle after HALT_WORD is pushed.
- Stable-output rule: instr, instr_pc and instr_valid are unchanged while instr_valid=1 and instr_ready=0, unless a redirect or reset occurs.
- Outputs come directly from queue registers. There is no combinational path from instr_ready or branch_valid to instr or instr_valid.

Test Plan:
1. Reset, then release; imem holds RAM[0]=E3A000AA, RAM[1]=E3A01055; instr_ready=1.
   -> Cycle 1: instr_valid=0.
   -> Next cycle: instr=E3A000AA, instr_pc=0, instr_pc8=8.
   -> Next cycle: instr=E3A01055, instr_pc=4.
2. Hold instr_ready=0 for 5 cycles after the first valid instruction.
   -> Queue fills to 2 entries; imem_a stays at 0x08.
   -> instr stays E3A000AA, instr_pc stays 0.
   -> On release, words 0x0, 0x4, 0x8 are delivered in order with no loss or duplication.
3. Assert branch_valid with branch_target=0x5A while the queue is full.
   -> Next edge: instr_valid=0, imem_a=0x58.
   -> The following cycle: instr=RAM[22]=E0036005, instr_pc=0x58.
4. Run the program straight through to RAM[122]=EAFFFFFE.
   -> halted=1 the cycle after instr_pc=0x1E8 enters the queue.
   -> imem_a frozen at 0x1E8.
   -> The halt word is delivered once; instr_valid=0 after it drains.
5. While halted, assert branch_valid with target 0x0.
   -> halted=0, and fetch resumes with E3A000AA.
6. Drive reset_n=0 for one cycle in the middle of scenario 2.
   -> Queue is emptied and instr_valid=0.
   -> Fetch restarts at RESET_PC.
   -> Separately, set RESET_PC=0xFFFFFFFC: the next fetch address wraps to 0x0.
